// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/response bundle between the execute stage and the
// iterative RV32M sequencer.
//   start   : request strobe (master -> slave)
//   funct3  : M-extension op select
//   rs1/rs2 : operands, sampled with start
//   flush   : abort whatever is in progress
//   busy    : sequencer occupied (slave -> master)
//   done    : one-cycle completion pulse, result valid
//   result  : registered result, held until the next completion
//   illegal : pulses with done for an op the build cannot execute
interface mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  busy, done, result, illegal
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output busy, done, result, illegal
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer.
// Radix-2 shift-add multiply and restoring divide over XLEN cycles on operand
// magnitudes, followed by one sign fix-up cycle and a one-cycle done pulse.
//
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : mdu_seq_if.slave (start/funct3/rs1/rs2/flush in,
//         busy/done/result/illegal out)
//
// Build option: define MDU_DIV_EN to include the divide path (divide loop,
// divide-by-zero and signed-overflow early-outs, remainder fix-up). Without
// it, any funct3[2]=1 op completes in one cycle with result 0 and illegal set.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  mdu_seq_if.slave  bus
);
  localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg, op_next;
  logic              s1_reg, s1_next;
  logic              s2_reg, s2_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  // Multiply: {high partial, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient in}.
  logic [2*XLEN-1:0] acc_reg, acc_next;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [XLEN-1:0]   opd_reg, opd_next;
  logic [XLEN-1:0]   result_reg, result_next;
`ifndef MDU_DIV_EN
  logic              illegal_reg, illegal_next;
`endif

  // Operand sign handling for the incoming request
  logic            rs1_signed, rs2_signed;
  logic            s1_in, s2_in;
  logic [XLEN-1:0] rs1_mag, rs2_mag;

  assign rs1_signed = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                      (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
  assign rs2_signed = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) ||
                      (bus.funct3 == 3'd6);
  assign s1_in   = rs1_signed & bus.rs1[XLEN-1];
  assign s2_in   = rs2_signed & bus.rs2[XLEN-1];
  assign rs1_mag = s1_in ? -bus.rs1 : bus.rs1;
  assign rs2_mag = s2_in ? -bus.rs2 : bus.rs2;

  // One shift-add step: add multiplicand into the high half when the
  // multiplier LSB is set, then shift the whole accumulator right, keeping
  // the carry out of the addition as the new MSB.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [2*XLEN-1:0] prod;

  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                    (acc_reg[0] ? {1'b0, opd_reg} : '0);
  assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};
  assign prod     = (s1_reg ^ s2_reg) ? -acc_reg : acc_reg;

`ifdef MDU_DIV_EN
  // One restoring step: shift remainder:dividend left, trial-subtract the
  // divisor, keep the difference and set the quotient bit when it is
  // non-negative. The remainder is always below the divisor, so the shifted
  // value fits XLEN bits whenever the trial goes negative.
  logic [XLEN:0]     div_shift, div_trial;
  logic [2*XLEN-1:0] div_step;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic              div_zero, div_ovf;

  assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
  assign div_trial = div_shift - {1'b0, opd_reg};
  assign div_step  = div_trial[XLEN]
                   ? {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                   : {div_trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
  assign quo_fix   = (s1_reg ^ s2_reg) ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
  assign rem_fix   = s1_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];

  assign div_zero  = (bus.rs2 == '0);
  // Most-negative / -1 only overflows for the signed ops (DIV, REM)
  assign div_ovf   = ((bus.funct3 == 3'd4) || (bus.funct3 == 3'd6)) &&
                     (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.rs2 == '1);
`endif

  // Next-state and datapath logic
  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    s1_next      = s1_reg;
    s2_next      = s2_reg;
    cnt_next     = cnt_reg;
    acc_next     = acc_reg;
    opd_next     = opd_reg;
    result_next  = result_reg;
`ifndef MDU_DIV_EN
    illegal_next = illegal_reg;
`endif

    if (bus.flush) begin
      // Abort leaves result (and everything else) untouched
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            op_next  = bus.funct3;
            s1_next  = s1_in;
            s2_next  = s2_in;
            cnt_next = CW'(XLEN - 1);
`ifdef MDU_DIV_EN
            if (bus.funct3[2] && div_zero) begin
              result_next = bus.funct3[1] ? bus.rs1 : '1;
              state_next  = DONE;
            end else if (bus.funct3[2] && div_ovf) begin
              result_next = bus.funct3[1] ? '0 : bus.rs1;
              state_next  = DONE;
            end else if (bus.funct3[2]) begin
              acc_next   = {{XLEN{1'b0}}, rs1_mag};
              opd_next   = rs2_mag;
              state_next = CALC;
            end else begin
              acc_next   = {{XLEN{1'b0}}, rs2_mag};
              opd_next   = rs1_mag;
              state_next = CALC;
            end
`else
            illegal_next = bus.funct3[2];
            if (bus.funct3[2]) begin
              result_next = '0;
              state_next  = DONE;
            end else begin
              acc_next   = {{XLEN{1'b0}}, rs2_mag};
              opd_next   = rs1_mag;
              state_next = CALC;
            end
`endif
          end
        end

        CALC: begin
`ifdef MDU_DIV_EN
          acc_next = op_reg[2] ? div_step : mul_step;
`else
          acc_next = mul_step;
`endif
          cnt_next = cnt_reg - CW'(1);
          if (cnt_reg == '0) begin
            state_next = FIX;
          end
        end

        FIX: begin
`ifdef MDU_DIV_EN
          if (op_reg[2]) begin
            result_next = op_reg[1] ? rem_fix : quo_fix;
          end else begin
            result_next = (op_reg == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          end
`else
          result_next = (op_reg == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`endif
          state_next = DONE;
        end

        DONE: begin
          state_next = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      op_reg      <= '0;
      s1_reg      <= 1'b0;
      s2_reg      <= 1'b0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      opd_reg     <= '0;
      result_reg  <= '0;
`ifndef MDU_DIV_EN
      illegal_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      s1_reg      <= s1_next;
      s2_reg      <= s2_next;
      cnt_reg     <= cnt_next;
      acc_reg     <= acc_next;
      opd_reg     <= opd_next;
      result_reg  <= result_next;
`ifndef MDU_DIV_EN
      illegal_reg <= illegal_next;
`endif
    end
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;
`ifdef MDU_DIV_EN
  assign bus.illegal = 1'b0;
`else
  assign bus.illegal = (state_reg == DONE) && illegal_reg;
`endif

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative sequencer for RV32M multiply/divide instructions. It sits beside the single-cycle ALU in the execute stage. When the decoder flags an M-extension op, it accepts the operands, runs a radix-2 shift-add or restoring-divide loop over `XLEN` cycles, fixes up signs, and returns a registered result with a one-cycle `done` pulse. The pipeline stalls on `busy` while the sequencer runs.

## Interface
- `XLEN`, default 32: operand/result width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request strobe; sampled only in IDLE.
- `funct3` in 3: M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1` in XLEN: first operand (multiplicand/dividend); sampled with `start`.
- `rs2` in XLEN: second operand (multiplier/divisor); sampled with `start`.
- `flush` in 1: abort any operation in progress.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; `result` is valid in this cycle.
- `result` out XLEN: registered result; held until the next completion.
- `illegal` out 1: pulses with `done` for an unsupported op (see Configuration).

## Operation
- States:
  - IDLE: wait for a request.
  - CALC: iteration loop.
  - FIX: sign correction and result selection.
  - DONE: `done` asserted.
- IDLE + `start` (and no `flush`):
  - Latch `funct3`.
  - Latch operand signs: rs1 signed for 1, 2, 4, 6; rs2 signed for 1, 4, 6.
  - Convert operands to magnitudes.
  - Load counter = XLEN-1 and go to CALC.
- CALC, multiply: 2·XLEN-bit accumulator; each cycle add the multiplicand when the multiplier LSB is 1, then shift. Leave when counter = 0.
- CALC, divide: restoring; shift remainder/quotient left 1, trial-subtract divisor, set quotient bit on non-negative. Leave when counter = 0.
- FIX (multiply):
  - Negate the full product if operand signs differ.
  - MUL selects the low XLEN bits; MULH/MULHSU/MULHU select the high XLEN bits.
- FIX (divide):
  - Quotient sign = s1 XOR s2.
  - Remainder sign = s1.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Write `result`, go to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- Early-out (IDLE → DONE directly, result written at the accept edge):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (rs1 = 100…0, rs2 = all ones): DIV → rs1; REM → 0.
- Reset: state IDLE, `busy` 0, `done` 0, `result` 0, `illegal` 0, counter 0.

## Timing
- Start accepted at edge 0. Normal path:
  - CALC occupies cycles 1..XLEN.
  - FIX occupies cycle XLEN+1.
  - `done` is high in cycle XLEN+2 (34 for XLEN=32).
- Early-out path: `done` is high in cycle 1.
- `busy` rises in cycle 1 and falls in the cycle after DONE.
- `start` while `busy` = 1 (including the DONE cycle) is ignored; no queuing.
- `flush` in any state: next edge → IDLE. `done`/`illegal` are not asserted and `result` is unchanged.
- `flush` and `start` in the same IDLE cycle: flush wins; the request is dropped.
- `rst` overrides `flush` and `start`; reset mid-operation discards the operation.
- Operands may change after the accept edge without effect.

## Configuration
- `MDU_DIV_EN` defined: divide path (divide loop, early-outs, remainder fix-up) is present. `illegal` is constant 0.
- `MDU_DIV_EN` undefined:
  - Divide hardware is removed.
  - `funct3[2]` = 1 takes the early-out path: `result` = 0 and `done` + `illegal` both high in cycle 1.
  - Multiply ops are unaffected.

## Test plan
- Signed multiply: MUL rs1 = 7, rs2 = 0xFFFFFFFD (−3) → `result` 0xFFFFFFEB, `done` in cycle 34, `busy` high cycles 1–34.
- High-word multiply: MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Signed divide/remainder: DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- Early-outs:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - All three: `done` in cycle 1.
- Flush and busy: `flush` in cycle 10 of a MUL → IDLE at cycle 11, no `done`, `result` keeps its prior value. A `start` pulsed in cycle 5 of a run is ignored, and `result` matches the first op.
- Build without `MDU_DIV_EN`: DIV 9 / 3 → `result` 0, `done` and `illegal` high in cycle 1; MUL 3 × 3 → 9, `illegal` 0.
